multi_pulse_stretcher: RTL

Multi-channel, runtime-programmable successor to the single-channel fixed-length pulse stretcher in the pixel_config path. Each channel turns a rising edge on its input into an output pulse exactly L clock cycles long. L is loaded at run time. A mode bit selects retriggerable or non-retriggerable operation. Per-channel enable masks and sticky drop flags support pixel-injection and readout-strobe generation across a column group.

---
 rtl/multi_pulse_stretcher.sv | 131 +++++++++++++
 1 files changed

// File: rtl/multi_pulse_stretcher.sv
// Multi-channel runtime-programmable pulse stretcher: each enabled rising edge
// produces an output pulse exactly L cycles long, retriggerable or not per edge.
//
// state     | meaning
// ----------+--------------------------------------------------------------
// ST_IDLE   | channel output low, counter 0, waiting for an accepted edge
// ST_ACTIVE | channel output high, counter holds remaining cycles (1..L)
module multi_pulse_stretcher #(
    parameter int N_CH           = 8,
    parameter int CNT_WIDTH      = 8,
    parameter int DEFAULT_LENGTH = 3
) (
    input  logic                 clk_in,
    input  logic                 rst,
    input  logic [N_CH-1:0]      pulse_in,
    input  logic [N_CH-1:0]      ch_enable,
    input  logic [CNT_WIDTH-1:0] length_in,
    input  logic                 length_load,
    input  logic                 retrig_mode,
    input  logic                 clear_dropped,
    output logic [N_CH-1:0]      pulse_out,
    output logic                 busy,
    output logic [N_CH-1:0]      dropped,
    output logic [CNT_WIDTH-1:0] length_cur
);

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } state_t;

    localparam logic [CNT_WIDTH-1:0] LEN_RST = CNT_WIDTH'(DEFAULT_LENGTH);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

    state_t               state_q [N_CH];
    state_t               state_d [N_CH];
    logic [CNT_WIDTH-1:0] cnt_q   [N_CH];
    logic [CNT_WIDTH-1:0] cnt_d   [N_CH];

    logic [N_CH-1:0]      prev_q;
    logic [N_CH-1:0]      trig;
    logic [N_CH-1:0]      pulse_q;
    logic [N_CH-1:0]      pulse_d;
    logic [N_CH-1:0]      drop_set;
    logic [N_CH-1:0]      dropped_q;
    logic [N_CH-1:0]      dropped_d;
    logic                 busy_q;
    logic [CNT_WIDTH-1:0] len_q;
    logic [CNT_WIDTH-1:0] len_d;

    assign trig = pulse_in & ~prev_q & ch_enable;

    // A zero length would never terminate, so it is stored as the shortest legal pulse.
    always_comb begin
        len_d = len_q;
        if (length_load) begin
            len_d = (length_in == '0) ? CNT_ONE : length_in;
        end
    end

    // Triggers always use len_q, so a same-edge load only affects later edges.
    always_comb begin
        for (int i = 0; i < N_CH; i++) begin
            state_d[i]  = state_q[i];
            cnt_d[i]    = cnt_q[i];
            pulse_d[i]  = pulse_q[i];
            drop_set[i] = 1'b0;
            case (state_q[i])
                ST_IDLE: begin
                    if (trig[i]) begin
                        state_d[i] = ST_ACTIVE;
                        cnt_d[i]   = len_q;
                        pulse_d[i] = 1'b1;
                    end
                end
                ST_ACTIVE: begin
                    if (trig[i] && retrig_mode) begin
                        cnt_d[i] = len_q;
                    end else begin
                        drop_set[i] = trig[i];
                        if (cnt_q[i] == CNT_ONE) begin
                            state_d[i] = ST_IDLE;
                            cnt_d[i]   = '0;
                            pulse_d[i] = 1'b0;
                        end else begin
                            cnt_d[i] = cnt_q[i] - CNT_ONE;
                        end
                    end
                end
                default: begin
                    state_d[i] = ST_IDLE;
                    cnt_d[i]   = '0;
                    pulse_d[i] = 1'b0;
                end
            endcase
        end
    end

    // A new drop on the same edge as a clear must survive.
    assign dropped_d = (clear_dropped ? '0 : dropped_q) | drop_set;

    always_ff @(posedge clk_in) begin
        if (rst) begin
            prev_q    <= '1;
            len_q     <= LEN_RST;
            pulse_q   <= '0;
            busy_q    <= 1'b0;
            dropped_q <= '0;
            for (int i = 0; i < N_CH; i++) begin
                state_q[i] <= ST_IDLE;
                cnt_q[i]   <= '0;
            end
        end else begin
            prev_q    <= pulse_in;
            len_q     <= len_d;
            pulse_q   <= pulse_d;
            busy_q    <= |pulse_d;
            dropped_q <= dropped_d;
            for (int i = 0; i < N_CH; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
        end
    end

    assign pulse_out  = pulse_q;
    assign busy       = busy_q;
    assign dropped    = dropped_q;
    assign length_cur = len_q;

endmodule
